// File: rtl/rgb_pwm_core.sv
// ---------------------------------------------------------------------------
// rgb_pwm_core
//
// Three-channel PWM generator for the RGB LED. It sits behind the led_pwm
// register file, which supplies control, prescaler and duty values.
//
// A prescaler divides aclk into "ticks". A period counter steps through
// 0 .. MAX-1 on each tick, where MAX = 2**CNT_WIDTH-1. Each channel compares
// the period counter against a shadow copy of its duty value.
//
// Shadows change only at period boundaries, so a pulse is never cut short or
// stretched by a register write.
//
// Optional feature (macro LED_PWM_FADE_EN):
//   undefined : shadows jump straight to duty_* at every wrap (default)
//   defined   : shadows step by one toward duty_* at every wrap, giving a
//               one-step-per-period brightness ramp. The IDLE->RUN load
//               still jumps.
//
// Ports
//   aclk         in   1            system clock
//   areset       in   1            synchronous active-high reset
//   ctrl_enable  in   1            1 = run, 0 = outputs off, counters held
//   presc_div    in   PRESC_WIDTH  one tick every presc_div+1 aclk cycles
//   duty_r       in   CNT_WIDTH    red on-ticks per period
//   duty_g       in   CNT_WIDTH    green on-ticks per period
//   duty_b       in   CNT_WIDTH    blue on-ticks per period
//   led_r        out  1            red PWM output, registered, active-high
//   led_g        out  1            green PWM output, registered, active-high
//   led_b        out  1            blue PWM output, registered, active-high
//   period_tick  out  1            one-cycle pulse on period counter wrap
// ---------------------------------------------------------------------------
module rgb_pwm_core #(
  parameter int CNT_WIDTH   = 8,
  parameter int PRESC_WIDTH = 16
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   ctrl_enable,
  input  logic [PRESC_WIDTH-1:0] presc_div,
  input  logic [CNT_WIDTH-1:0]   duty_r,
  input  logic [CNT_WIDTH-1:0]   duty_g,
  input  logic [CNT_WIDTH-1:0]   duty_b,
  output logic                   led_r,
  output logic                   led_g,
  output logic                   led_b,
  output logic                   period_tick
);

  // Last period count value (MAX-1). The period is MAX ticks long, so a
  // duty of MAX keeps the output high for the whole period.
  localparam logic [CNT_WIDTH-1:0] PER_LAST = CNT_WIDTH'((2 ** CNT_WIDTH) - 2);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e                 state_q;
  logic [PRESC_WIDTH-1:0] presCnt_q;
  logic [CNT_WIDTH-1:0]   perCnt_q;
  logic [CNT_WIDTH-1:0]   shadowR_q;
  logic [CNT_WIDTH-1:0]   shadowG_q;
  logic [CNT_WIDTH-1:0]   shadowB_q;
  logic [CNT_WIDTH-1:0]   shadowR_d;
  logic [CNT_WIDTH-1:0]   shadowG_d;
  logic [CNT_WIDTH-1:0]   shadowB_d;
  logic                   ledR_q;
  logic                   ledG_q;
  logic                   ledB_q;
  logic                   periodTick_q;
  logic                   presTick;
  logic                   perWrap;

  // The prescaler uses >= rather than ==. If presc_div is lowered below the
  // current count, the prescaler wraps on the next cycle instead of running
  // all the way around its range.
  assign presTick = (presCnt_q >= presc_div);
  assign perWrap  = presTick && (perCnt_q == PER_LAST);

`ifdef LED_PWM_FADE_EN
  // Moves a shadow one step toward its target, or holds it when they match.
  function automatic logic [CNT_WIDTH-1:0] stepToward(
    input logic [CNT_WIDTH-1:0] cur,
    input logic [CNT_WIDTH-1:0] target
  );
    logic [CNT_WIDTH-1:0] res;
    res = cur;
    if (cur < target) begin
      res = cur + 1'b1;
    end else if (cur > target) begin
      res = cur - 1'b1;
    end
    return res;
  endfunction

  // Values loaded into the shadows at a period wrap: one step toward the duty.
  always_comb begin
    shadowR_d = stepToward(shadowR_q, duty_r);
    shadowG_d = stepToward(shadowG_q, duty_g);
    shadowB_d = stepToward(shadowB_q, duty_b);
  end
`else
  // Values loaded into the shadows at a period wrap: the duty inputs directly.
  always_comb begin
    shadowR_d = duty_r;
    shadowG_d = duty_g;
    shadowB_d = duty_b;
  end
`endif

  // Control FSM, counters, shadows and registered outputs.
  //
  // In IDLE the counters stay cleared and the LEDs stay off. Entering RUN
  // loads the shadows straight from the duty inputs, so a fresh enable never
  // ramps.
  //
  // In RUN the LEDs compare the current period count with the current
  // shadows. This gives one cycle of latency from perCnt_q to led_*.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= IDLE;
      presCnt_q    <= '0;
      perCnt_q     <= '0;
      shadowR_q    <= '0;
      shadowG_q    <= '0;
      shadowB_q    <= '0;
      ledR_q       <= 1'b0;
      ledG_q       <= 1'b0;
      ledB_q       <= 1'b0;
      periodTick_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          presCnt_q    <= '0;
          perCnt_q     <= '0;
          ledR_q       <= 1'b0;
          ledG_q       <= 1'b0;
          ledB_q       <= 1'b0;
          periodTick_q <= 1'b0;
          if (ctrl_enable) begin
            state_q   <= RUN;
            shadowR_q <= duty_r;
            shadowG_q <= duty_g;
            shadowB_q <= duty_b;
          end
        end

        RUN: begin
          if (!ctrl_enable) begin
            state_q      <= IDLE;
            presCnt_q    <= '0;
            perCnt_q     <= '0;
            ledR_q       <= 1'b0;
            ledG_q       <= 1'b0;
            ledB_q       <= 1'b0;
            periodTick_q <= 1'b0;
          end else begin
            ledR_q       <= (perCnt_q < shadowR_q);
            ledG_q       <= (perCnt_q < shadowG_q);
            ledB_q       <= (perCnt_q < shadowB_q);
            periodTick_q <= perWrap;
            if (presTick) begin
              presCnt_q <= '0;
              if (perWrap) begin
                perCnt_q  <= '0;
                shadowR_q <= shadowR_d;
                shadowG_q <= shadowG_d;
                shadowB_q <= shadowB_d;
              end else begin
                perCnt_q <= perCnt_q + 1'b1;
              end
            end else begin
              presCnt_q <= presCnt_q + 1'b1;
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign led_r       = ledR_q;
  assign led_g       = ledG_q;
  assign led_b       = ledB_q;
  assign period_tick = periodTick_q;

endmodule

// File: tb/tb_rgb_pwm_core.sv
// ---------------------------------------------------------------------------
// tb_rgb_pwm_core
//
// Directed testbench for rgb_pwm_core using the default 8-bit counters.
// Inputs change on the falling edge of aclk, and outputs are sampled on the
// falling edge.
//
// Expected counts are worked out by hand from the period structure:
//   - a period lasts 255 ticks;
//   - the LED goes high one cycle after the counter reaches a value below
//     the shadow.
// ---------------------------------------------------------------------------
module tb_rgb_pwm_core;

  localparam int CNT_WIDTH   = 8;
  localparam int PRESC_WIDTH = 16;
  localparam int TICK_LIMIT  = 3000;

  // Red high-tick counts for the four periods after duty_r moves from 10 to
  // 13, plus the expected counts around the mid-period and wrap-cycle writes.
`ifdef LED_PWM_FADE_EN
  localparam int FADE_EXP0     = 11;
  localparam int FADE_EXP1     = 12;
  localparam int FADE_EXP2     = 13;
  localparam int FADE_EXP3     = 13;
  localparam int NEXT_PER_R    = 65;
  localparam int CAPT_BEFORE_R = 66;
  localparam int CAPT_AFTER_R  = 65;
`else
  localparam int FADE_EXP0     = 13;
  localparam int FADE_EXP1     = 13;
  localparam int FADE_EXP2     = 13;
  localparam int FADE_EXP3     = 13;
  localparam int NEXT_PER_R    = 128;
  localparam int CAPT_BEFORE_R = 128;
  localparam int CAPT_AFTER_R  = 32;
`endif

  logic                   aclk;
  logic                   areset;
  logic                   ctrlEnable;
  logic [PRESC_WIDTH-1:0] prescDiv;
  logic [CNT_WIDTH-1:0]   dutyR;
  logic [CNT_WIDTH-1:0]   dutyG;
  logic [CNT_WIDTH-1:0]   dutyB;
  logic                   ledR;
  logic                   ledG;
  logic                   ledB;
  logic                   periodTick;

  int errors = 0;
  int checks = 0;
  int hr;
  int hg;
  int hb;
  int tk;
  int ft;
  int cyc;
  int partA;
  int fadeExp [4];

  rgb_pwm_core #(
    .CNT_WIDTH  (CNT_WIDTH),
    .PRESC_WIDTH(PRESC_WIDTH)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .ctrl_enable(ctrlEnable),
    .presc_div  (prescDiv),
    .duty_r     (dutyR),
    .duty_g     (dutyG),
    .duty_b     (dutyB),
    .led_r      (ledR),
    .led_g      (ledG),
    .led_b      (ledB),
    .period_tick(periodTick)
  );

  // 10 ns clock.
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Compares one observed value against its expected value and tallies it.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drives all control inputs together.
  task automatic applyStimulus(input logic en, input int presc, input int r, input int g,
                               input int b);
    ctrlEnable = en;
    prescDiv   = PRESC_WIDTH'(presc);
    dutyR      = CNT_WIDTH'(r);
    dutyG      = CNT_WIDTH'(g);
    dutyB      = CNT_WIDTH'(b);
  endtask

  // Samples n falling edges, counting LED-high cycles and period ticks.
  // firstTick holds the 1-based index of the first tick, or 0 if none.
  task automatic runWindow(input int n, output int highR, output int highG, output int highB,
                           output int ticks, output int firstTick);
    highR     = 0;
    highG     = 0;
    highB     = 0;
    ticks     = 0;
    firstTick = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge aclk);
      if (ledR === 1'b1) highR++;
      if (ledG === 1'b1) highG++;
      if (ledB === 1'b1) highB++;
      if (periodTick === 1'b1) begin
        ticks++;
        if (firstTick == 0) firstTick = i;
      end
    end
  endtask

  // Counts falling edges until period_tick is seen, bounded by TICK_LIMIT.
  task automatic waitTick(output int cycles);
    cycles = 0;
    do begin
      @(negedge aclk);
      cycles++;
    end while (periodTick !== 1'b1 && cycles < TICK_LIMIT);
  endtask

  // Watchdog so the run always ends even if the sequence gets stuck.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    fadeExp[0] = FADE_EXP0;
    fadeExp[1] = FADE_EXP1;
    fadeExp[2] = FADE_EXP2;
    fadeExp[3] = FADE_EXP3;

    // Reset is held for three cycles, then released with the core disabled.
    areset = 1'b1;
    applyStimulus(1'b0, 0, 0, 0, 0);
    repeat (3) @(negedge aclk);
    checkOutput("rstLeds", int'({ledR, ledG, ledB}), 0);
    checkOutput("rstTick", int'(periodTick), 0);
    areset = 1'b0;
    applyStimulus(1'b0, 0, 64, 0, 255);
    runWindow(20, hr, hg, hb, tk, ft);
    checkOutput("idleR", hr, 0);
    checkOutput("idleB", hb, 0);
    checkOutput("idleTicks", tk, 0);

    // presc 0, duties 64/0/255: the first period includes the enable latency.
    applyStimulus(1'b1, 0, 64, 0, 255);
    runWindow(256, hr, hg, hb, tk, ft);
    checkOutput("p0FirstR", hr, 64);
    checkOutput("p0FirstG", hg, 0);
    checkOutput("p0FirstB", hb, 255);
    checkOutput("p0FirstTickAt", ft, 256);
    runWindow(255, hr, hg, hb, tk, ft);
    checkOutput("p0SteadyR", hr, 64);
    checkOutput("p0SteadyG", hg, 0);
    checkOutput("p0SteadyB", hb, 255);
    checkOutput("p0SteadyTicks", tk, 1);
    checkOutput("p0SteadyTickAt", ft, 255);

    // presc 3, duty_r 10, entered through a disable/enable cycle.
    applyStimulus(1'b0, 3, 10, 0, 255);
    @(negedge aclk);
    applyStimulus(1'b1, 3, 10, 0, 255);
    runWindow(1021, hr, hg, hb, tk, ft);
    checkOutput("p3R", hr, 40);
    checkOutput("p3B", hb, 1020);
    checkOutput("p3TickAt", ft, 1021);

    // Lower presc_div from 3 to 1 while presc_cnt is 2: tick on the next cycle.
    repeat (2) @(negedge aclk);
    applyStimulus(1'b1, 1, 10, 0, 255);
    waitTick(cyc);
    checkOutput("prescLowerPeriod", cyc, 509);
    waitTick(cyc);
    checkOutput("presc1Period", cyc, 510);

    // Mid-period duty write: the current period keeps 64, the next follows it.
    applyStimulus(1'b0, 0, 64, 0, 255);
    @(negedge aclk);
    applyStimulus(1'b1, 0, 64, 0, 255);
    runWindow(256, hr, hg, hb, tk, ft);
    checkOutput("midBaseR", hr, 64);
    checkOutput("midBaseTickAt", ft, 256);
    runWindow(100, hr, hg, hb, tk, ft);
    partA = hr;
    applyStimulus(1'b1, 0, 128, 0, 255);
    runWindow(155, hr, hg, hb, tk, ft);
    checkOutput("midWriteCurR", partA + hr, 64);
    runWindow(255, hr, hg, hb, tk, ft);
    checkOutput("midWriteNextR", hr, NEXT_PER_R);
    checkOutput("midWriteTickAt", ft, 255);

    // Write 32 in the wrap cycle and 200 just after: the wrap captures 32.
    runWindow(254, hr, hg, hb, tk, ft);
    checkOutput("captBeforeR", hr, CAPT_BEFORE_R);
    applyStimulus(1'b1, 0, 32, 0, 255);
    @(negedge aclk);
    applyStimulus(1'b1, 0, 200, 0, 255);
    runWindow(255, hr, hg, hb, tk, ft);
    checkOutput("captWrapR", hr, CAPT_AFTER_R);

    // Disable mid-period: the LEDs drop one cycle later and then stay off.
    applyStimulus(1'b0, 0, 255, 0, 255);
    @(negedge aclk);
    applyStimulus(1'b1, 0, 255, 0, 255);
    repeat (2) @(negedge aclk);
    checkOutput("fullOnR", int'(ledR), 1);
    checkOutput("fullOnB", int'(ledB), 1);
    applyStimulus(1'b0, 0, 255, 0, 255);
    @(negedge aclk);
    checkOutput("disableR", int'(ledR), 0);
    checkOutput("disableB", int'(ledB), 0);
    runWindow(50, hr, hg, hb, tk, ft);
    checkOutput("disabledHighR", hr, 0);
    checkOutput("disabledTicks", tk, 0);

    // Re-enable restarts from count 0 with freshly loaded shadows.
    applyStimulus(1'b1, 0, 5, 3, 255);
    runWindow(256, hr, hg, hb, tk, ft);
    checkOutput("reenR", hr, 5);
    checkOutput("reenG", hg, 3);
    checkOutput("reenTickAt", ft, 256);

    // Load shadow 10 on enable, then write 13: watch the following periods.
    applyStimulus(1'b0, 0, 10, 0, 0);
    @(negedge aclk);
    applyStimulus(1'b1, 0, 10, 0, 0);
    @(negedge aclk);
    applyStimulus(1'b1, 0, 13, 0, 0);
    runWindow(255, hr, hg, hb, tk, ft);
    checkOutput("fadeStartR", hr, 10);
    checkOutput("fadeStartTickAt", ft, 255);
    for (int k = 0; k < 4; k++) begin
      runWindow(255, hr, hg, hb, tk, ft);
      checkOutput($sformatf("fadePeriod%0dR", k), hr, fadeExp[k]);
    end

    // Reset while running overrides everything on the next edge.
    @(negedge aclk);
    checkOutput("preResetR", int'(ledR), 1);
    areset = 1'b1;
    @(negedge aclk);
    checkOutput("midResetR", int'(ledR), 0);
    checkOutput("midResetTick", int'(periodTick), 0);
    areset = 1'b0;
    runWindow(256, hr, hg, hb, tk, ft);
    checkOutput("postResetR", hr, 13);
    checkOutput("postResetTickAt", ft, 256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
